btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 20 ++
 rtl/btn_debounce_if.sv | 20 ++
 rtl/btn_debounce_ch.sv | 153 +++++++++++++++
 rtl/btn_debounce.sv | 45 ++++
 tb/tb_btn_debounce.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and default constants for the button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } btn_state_e;

    localparam int DEF_NUM_BTN         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_LONG_CYCLES     = 25000000;

    // A channel counts as pressed once a press is accepted until its release is accepted.
    function automatic logic is_held(input btn_state_e st);
        return (st == ST_DOWN) || (st == ST_WAIT_UP);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw active-low inputs plus debounced level and event pulses.
interface btn_debounce_if #(
    parameter int W = 2
);
    logic [W-1:0] btn;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_press;
    logic [W-1:0] btn_release;
    logic [W-1:0] btn_long;

    modport master (
        output btn,
        input  btn_level, btn_press, btn_release, btn_long
    );

    modport slave (
        input  btn,
        output btn_level, btn_press, btn_release, btn_long
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, four-state FSM, registered pulses.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    btn_debounce_if.slave ch
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             s_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchronizer input: raw button is active-low, internal sense is active-high.
    always_comb begin
        sync_d = {sync_q[0], ~ch.btn[0]};
    end

    assign s_s = sync_q[1];

    // Next state and debounce counter; counter only runs in the two WAIT states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UP: begin
                if (s_s) begin
                    state_d = ST_WAIT_DOWN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_WAIT_DOWN: begin
                if (!s_s) begin
                    state_d = ST_UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DOWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!s_s) begin
                    state_d = ST_WAIT_UP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DOWN;
                end
            end
            ST_WAIT_UP: begin
                if (s_s) begin
                    state_d = ST_DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_UP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the transition being taken, so outputs line up with the state change.
    always_comb begin
        level_d   = is_held(state_d);
        press_d   = (state_q == ST_WAIT_DOWN) && (state_d == ST_DOWN);
        release_d = (state_q == ST_WAIT_UP) && (state_d == ST_UP);
    end

    // Channel state, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign ch.btn_level   = level_q;
    assign ch.btn_press   = press_q;
    assign ch.btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int              HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold counter restarts only on a fresh press, so a bouncy release cannot re-fire btn_long.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (is_held(state_q)) begin
            long_d = (hold_q == HOLD_FIRE);
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                hold_d = hold_q;
            end
        end else begin
            hold_d = '0;
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign ch.btn_long = long_q;
`else
    assign ch.btn_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer top; one btn_debounce_ch per button.
// Define BTN_LONG_PRESS_EN to enable the btn_long hold detector.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 2)) begin : g_bad_params
        $error("btn_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must both be at least 2");
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_debounce_if #(.W(1)) ch_if ();

        assign ch_if.btn        = btn[gi];
        assign btn_level[gi]    = ch_if.btn_level;
        assign btn_press[gi]    = ch_if.btn_press;
        assign btn_release[gi]  = ch_if.btn_release;
        assign btn_long[gi]     = ch_if.btn_long;

        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ch    (ch_if.slave)
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: table vectors, directed corner cases, random stimulus vs. reference model.
module tb_btn_debounce;

    localparam int NB = 2;
    localparam int DC = 4;
    localparam int LC = 10;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int LN = LONG_EN ? 1 : 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btn_debounce_if #(.W(NB)) bus ();

    btn_debounce #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (bus.btn),
        .btn_level   (bus.btn_level),
        .btn_press   (bus.btn_press),
        .btn_release (bus.btn_release),
        .btn_long    (bus.btn_long)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a change is accepted once the last DC+1 samples seen
    // by the debouncer all disagree with the accepted level.
    logic [NB-1:0] m_p1, m_p2, m_p3;
    logic [NB-1:0] m_win [DC+1];
    logic [NB-1:0] m_level, m_press, m_rel, m_long;
    int            m_since [NB];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_p3 = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k <= DC; k++) m_win[k] = '0;
        for (int c = 0; c < NB; c++) m_since[c] = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] s;
        bit            all_opp;
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = ~bus.btn;
        for (int k = DC; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = s;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < NB; c++) begin
            if (m_level[c]) begin
                m_since[c]++;
                if (LONG_EN && (m_since[c] == LC)) m_long[c] = 1'b1;
            end
            all_opp = 1'b1;
            for (int k = 0; k <= DC; k++) begin
                if (m_win[k][c] == m_level[c]) all_opp = 1'b0;
            end
            if (all_opp) begin
                if (!m_level[c]) begin
                    m_press[c] = 1'b1;
                    m_since[c] = 0;
                end else begin
                    m_rel[c] = 1'b1;
                end
                m_level[c] = ~m_level[c];
            end
        end
    endtask

    // One clock: advance model at the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        check("model_level",   bus.btn_level,   m_level);
        check("model_press",   bus.btn_press,   m_press);
        check("model_release", bus.btn_release, m_rel);
        check("model_long",    bus.btn_long,    m_long);
    endtask

    typedef struct {
        logic [NB-1:0] btn;
        int            cycles;
        logic [NB-1:0] exp_level;
        int            exp_press;
        int            exp_rel;
        int            exp_long;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n_press, n_rel, n_long, t_press, t_long;

        tbl[0] = '{btn: 2'b11, cycles: 10, exp_level: 2'b00, exp_press: 0, exp_rel: 0, exp_long: 0};
        tbl[1] = '{btn: 2'b10, cycles: 12, exp_level: 2'b01, exp_press: 1, exp_rel: 0, exp_long: 0};
        tbl[2] = '{btn: 2'b11, cycles: 3,  exp_level: 2'b01, exp_press: 0, exp_rel: 0, exp_long: 0};
        tbl[3] = '{btn: 2'b10, cycles: 10, exp_level: 2'b01, exp_press: 0, exp_rel: 0, exp_long: LN};
        tbl[4] = '{btn: 2'b00, cycles: 12, exp_level: 2'b11, exp_press: 1, exp_rel: 0, exp_long: 0};
        tbl[5] = '{btn: 2'b11, cycles: 12, exp_level: 2'b00, exp_press: 0, exp_rel: 2, exp_long: LN};
        tbl[6] = '{btn: 2'b01, cycles: 12, exp_level: 2'b10, exp_press: 1, exp_rel: 0, exp_long: 0};
        tbl[7] = '{btn: 2'b11, cycles: 12, exp_level: 2'b00, exp_press: 0, exp_rel: 1, exp_long: LN};

        bus.btn = '1;
        rst_n   = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_level",   bus.btn_level,   0);
        check("reset_press",   bus.btn_press,   0);
        check("reset_release", bus.btn_release, 0);
        check("reset_long",    bus.btn_long,    0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.btn = tbl[i].btn;
            n_press = 0; n_rel = 0; n_long = 0;
            for (int j = 0; j < tbl[i].cycles; j++) begin
                tick();
                n_press += $countones(bus.btn_press);
                n_rel   += $countones(bus.btn_release);
                n_long  += $countones(bus.btn_long);
            end
            check($sformatf("tbl%0d_level", i),   bus.btn_level, tbl[i].exp_level);
            check($sformatf("tbl%0d_press", i),   n_press,       tbl[i].exp_press);
            check($sformatf("tbl%0d_release", i), n_rel,         tbl[i].exp_rel);
            check($sformatf("tbl%0d_long", i),    n_long,        tbl[i].exp_long);
        end

        // Short low glitch on btn[0] must leave every output untouched.
        bus.btn = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("glitch_level", bus.btn_level, 0);
            check("glitch_pulse", {bus.btn_press, bus.btn_release, bus.btn_long}, 0);
        end
        bus.btn = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch_level", bus.btn_level, 0);
            check("glitch_pulse", {bus.btn_press, bus.btn_release, bus.btn_long}, 0);
        end

        // Press latency: accepted on the 7th rising edge, pulse one cycle wide.
        bus.btn = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("lat_press_e%0d", k), bus.btn_press[0], (k == 7) ? 1 : 0);
            check($sformatf("lat_level_e%0d", k), bus.btn_level[0], (k >= 7) ? 1 : 0);
        end

        // Reset while held: outputs clear at once, press re-accepted after full latency.
        rst_n = 1'b0;
        #1;
        check("midrst_level", bus.btn_level, 0);
        check("midrst_pulse", {bus.btn_press, bus.btn_release, bus.btn_long}, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rst_press_e%0d", k), bus.btn_press[0], (k == 7) ? 1 : 0);
            check($sformatf("rst_level_e%0d", k), bus.btn_level[0], (k >= 7) ? 1 : 0);
        end

        // Release on channel 1 while channel 0 stays held and quiet.
        bus.btn = 2'b00;
        repeat (10) tick();
        bus.btn = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rel1_pulse_e%0d", k), bus.btn_release[1], (k == 7) ? 1 : 0);
            check($sformatf("rel1_level_e%0d", k), bus.btn_level[1], (k < 7) ? 1 : 0);
            check("rel1_ch0_quiet", {bus.btn_press[0], bus.btn_release[0], bus.btn_level[0]}, 3'b001);
        end

        // Both buttons pressed on the same edge.
        bus.btn = 2'b11;
        repeat (12) tick();
        bus.btn = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("both_press_e%0d", k), bus.btn_press, (k == 7) ? 3 : 0);
        end

        // Hold btn[0] for 30 cycles: one long pulse, 10 cycles after the press.
        bus.btn = 2'b11;
        repeat (12) tick();
        bus.btn = 2'b10;
        n_long = 0; t_press = -1; t_long = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.btn_press[0]) t_press = k;
            if (bus.btn_long[0]) begin
                n_long++;
                t_long = k;
            end
        end
        check("hold_press_edge", t_press, 7);
        check("hold_long_count", n_long, LN);
`ifdef BTN_LONG_PRESS_EN
        check("hold_long_delay", t_long - t_press, LC);
`endif
        bus.btn = 2'b11;
        repeat (12) tick();

        // Random stimulus: per-bit flips give a mix of glitches and stable holds.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 9) == 0) bus.btn[c] = ~bus.btn[c];
            end
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                check("rnd_rst_level", bus.btn_level, 0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
